w0rm_core_branch_unit: RTL and testbench

Parametrised two-stage branch resolution unit for the W0RM core, sitting after the ALU flag stage and ahead of fetch. It evaluates a 16-entry condition-code set against the ALU flags and computes relative, absolute, call and return targets. A configurable-depth return-address stack (RAS) resolves returns. On a taken branch it raises `flush_pipeline` and `next_pc_valid` and, for calls, produces the link value.

---
 rtl/w0rm_core_branch_unit_if.sv | 53 +++++
 rtl/w0rm_core_branch_unit.sv | 164 ++++++++++++++++
 tb/tb_w0rm_core_branch_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/w0rm_core_branch_unit_if.sv
// Branch unit bus: instruction/flag inputs from the ALU flag stage and
// resolved-target, link, RAS event and sideband outputs toward fetch.
// master = upstream/fetch side, slave = branch unit.
interface w0rm_core_branch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
);
    logic                  mem_ready;
    logic                  branch_ready;
    logic                  data_valid;
    logic                  is_branch;
    logic                  is_cond_branch;
    logic [3:0]            cond_code;
    logic                  alu_flag_zero;
    logic                  alu_flag_negative;
    logic                  alu_flag_carry;
    logic                  alu_flag_overflow;
    logic [ADDR_WIDTH-1:0] branch_base_addr;
    logic [1:0]            branch_mode;
    logic [DATA_WIDTH-1:0] rn;
    logic [DATA_WIDTH-1:0] lit;
    logic                  branch_valid;
    logic                  flush_pipeline;
    logic                  next_pc_valid;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [DATA_WIDTH-1:0] next_link_reg;
    logic                  link_valid;
    logic                  ras_overflow;
    logic                  ras_underflow;
    logic [USER_WIDTH-1:0] user_data_in;
    logic [USER_WIDTH-1:0] user_data_out;

    modport master (
        output mem_ready, data_valid, is_branch, is_cond_branch,
        output cond_code, alu_flag_zero, alu_flag_negative,
        output alu_flag_carry, alu_flag_overflow,
        output branch_base_addr, branch_mode, rn, lit, user_data_in,
        input  branch_ready, branch_valid, flush_pipeline,
        input  next_pc_valid, next_pc, next_link_reg, link_valid,
        input  ras_overflow, ras_underflow, user_data_out
    );

    modport slave (
        input  mem_ready, data_valid, is_branch, is_cond_branch,
        input  cond_code, alu_flag_zero, alu_flag_negative,
        input  alu_flag_carry, alu_flag_overflow,
        input  branch_base_addr, branch_mode, rn, lit, user_data_in,
        output branch_ready, branch_valid, flush_pipeline,
        output next_pc_valid, next_pc, next_link_reg, link_valid,
        output ras_overflow, ras_underflow, user_data_out
    );
endinterface

// File: rtl/w0rm_core_branch_unit.sv
// Two-stage branch resolution: S1 captures, S2 evaluates condition,
// target and RAS, registering all outputs. Ports: clk, reset_n, bu (slave).
module w0rm_core_branch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int RAS_DEPTH  = 4,
    parameter int INSN_BYTES = 2
) (
    input logic clk,
    input logic reset_n,
    w0rm_core_branch_unit_if.slave bu
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(INSN_BYTES);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
    localparam logic [1:0] MODE_REL  = 2'd0;
    localparam logic [1:0] MODE_ABS  = 2'd1;
    localparam logic [1:0] MODE_CALL = 2'd2;
    localparam logic [1:0] MODE_RET  = 2'd3;

    logic                  s1_valid;
    logic                  s1_cond_en;
    logic [3:0]            s1_cc;
    logic                  s1_z, s1_n, s1_c, s1_v;
    logic [ADDR_WIDTH-1:0] s1_base;
    logic [1:0]            s1_mode;
    logic [DATA_WIDTH-1:0] s1_rn;
    logic [DATA_WIDTH-1:0] s1_lit;
    logic [USER_WIDTH-1:0] s1_user;

    logic                  bv_q, flush_q, lv_q, ovf_q, unf_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] link_q;
    logic [USER_WIDTH-1:0] user_q;

    logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]         top;
    logic [CW-1:0]         cnt;

    logic                  accept;
    logic                  cond_true;
    logic                  s2_go;
    logic                  taken;
    logic                  push, pop, unf;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [ADDR_WIDTH-1:0] tgt;
    logic [PW-1:0]         top_inc;
    logic [PW-1:0]         top_dec;

    // flush_q already implies the previous edge saw mem_ready
    assign accept = bu.data_valid & bu.is_branch & bu.mem_ready & ~flush_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
        end else if (bu.mem_ready) begin
            s1_valid <= accept;
            if (accept) begin
                s1_cond_en <= bu.is_cond_branch;
                s1_cc      <= bu.cond_code;
                s1_z       <= bu.alu_flag_zero;
                s1_n       <= bu.alu_flag_negative;
                s1_c       <= bu.alu_flag_carry;
                s1_v       <= bu.alu_flag_overflow;
                s1_base    <= bu.branch_base_addr;
                s1_mode    <= bu.branch_mode;
                s1_rn      <= bu.rn;
                s1_lit     <= bu.lit;
                s1_user    <= bu.user_data_in;
            end
        end
    end

    always_comb begin
        cond_true = 1'b0;
        unique case (s1_cc)
            4'd0:  cond_true = s1_z;
            4'd1:  cond_true = ~s1_z;
            4'd2:  cond_true = s1_c;
            4'd3:  cond_true = ~s1_c;
            4'd4:  cond_true = s1_v;
            4'd5:  cond_true = ~s1_v;
            4'd6:  cond_true = s1_n;
            4'd7:  cond_true = ~s1_n;
            4'd8:  cond_true = s1_c & ~s1_z;
            4'd9:  cond_true = ~s1_c | s1_z;
            4'd10: cond_true = s1_n == s1_v;
            4'd11: cond_true = s1_n != s1_v;
            4'd12: cond_true = ~s1_z & (s1_n == s1_v);
            4'd13: cond_true = s1_z | (s1_n != s1_v);
            4'd14: cond_true = 1'b1;
            4'd15: cond_true = 1'b0;
        endcase
    end

    // an instruction sitting in S1 during a flush cycle is squashed
    assign s2_go    = s1_valid & ~flush_q;
    assign taken    = s2_go & (~s1_cond_en | cond_true);
    assign ret_addr = s1_base + INC;
    assign push     = taken & (s1_mode == MODE_CALL);
    assign pop      = taken & (s1_mode == MODE_RET) & (cnt != '0);
    assign unf      = taken & (s1_mode == MODE_RET) & (cnt == '0);
    assign top_inc  = top + PW'(1);
    assign top_dec  = top - PW'(1);

    always_comb begin
        tgt = '0;
        unique case (s1_mode)
            MODE_REL, MODE_CALL:
                tgt = s1_base + ADDR_WIDTH'($signed(s1_lit)) + INC;
            MODE_ABS:
                tgt = ADDR_WIDTH'(s1_rn);
            MODE_RET:
                tgt = (cnt != '0) ? ras[top] : ADDR_WIDTH'(s1_rn);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bv_q    <= 1'b0;
            flush_q <= 1'b0;
            lv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            pc_q    <= '0;
            link_q  <= '0;
            user_q  <= '0;
            top     <= '0;
            cnt     <= '0;
        end else if (bu.mem_ready) begin
            bv_q    <= s2_go;
            flush_q <= taken;
            lv_q    <= push;
            ovf_q   <= push & (cnt == FULL);
            unf_q   <= unf;
            pc_q    <= taken ? tgt : '0;
            link_q  <= push ? DATA_WIDTH'(ret_addr) : '0;
            user_q  <= taken ? s1_user : '0;
            // full stack: overwrite oldest, count saturates
            if (push) begin
                ras[top_inc] <= ret_addr;
                top          <= top_inc;
                if (cnt != FULL) cnt <= cnt + CW'(1);
            end else if (pop) begin
                top <= top_dec;
                cnt <= cnt - CW'(1);
            end
        end
    end

    // pulses are held through a stall and shown once mem_ready returns
    assign bu.branch_ready   = bu.mem_ready;
    assign bu.branch_valid   = bv_q & bu.mem_ready;
    assign bu.flush_pipeline = flush_q & bu.mem_ready;
    assign bu.next_pc_valid  = flush_q & bu.mem_ready;
    assign bu.link_valid     = lv_q & bu.mem_ready;
    assign bu.ras_overflow   = ovf_q & bu.mem_ready;
    assign bu.ras_underflow  = unf_q & bu.mem_ready;
    assign bu.next_pc        = pc_q;
    assign bu.next_link_reg  = link_q;
    assign bu.user_data_out  = user_q;
endmodule

// File: tb/tb_w0rm_core_branch_unit.sv
// Directed bench for w0rm_core_branch_unit: vector table plus
// flush, stall and reset sequences.
module tb_w0rm_core_branch_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    w0rm_core_branch_unit_if #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1)
    ) bif ();

    w0rm_core_branch_unit #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1),
        .RAS_DEPTH(4), .INSN_BYTES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bu(bif.slave)
    );

    typedef struct {
        logic        cen;
        logic [3:0]  cc;
        logic [3:0]  f;
        logic [1:0]  mode;
        logic [31:0] base;
        logic [31:0] rn;
        logic [31:0] lit;
        logic        tk;
        logic [31:0] pc;
        logic [31:0] link;
        logic        lv;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic cen, logic [3:0] cc, logic [3:0] f, logic [1:0] mode,
        logic [31:0] base, logic [31:0] rn, logic [31:0] lit,
        logic tk, logic [31:0] pc, logic [31:0] link,
        logic lv, logic ovf, logic unf);
        vec_t v;
        v.cen = cen; v.cc = cc; v.f = f; v.mode = mode;
        v.base = base; v.rn = rn; v.lit = lit;
        v.tk = tk; v.pc = pc; v.link = link;
        v.lv = lv; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bif.data_valid        = 1'b1;
        bif.is_branch         = 1'b1;
        bif.is_cond_branch    = v.cen;
        bif.cond_code         = v.cc;
        bif.alu_flag_zero     = v.f[3];
        bif.alu_flag_negative = v.f[2];
        bif.alu_flag_carry    = v.f[1];
        bif.alu_flag_overflow = v.f[0];
        bif.branch_mode       = v.mode;
        bif.branch_base_addr  = v.base;
        bif.rn                = v.rn;
        bif.lit               = v.lit;
        bif.user_data_in      = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(string nm, vec_t v);
        chk({nm, ".bv"}, 64'(bif.branch_valid), 64'(1));
        chk({nm, ".flush"}, 64'(bif.flush_pipeline), 64'(v.tk));
        chk({nm, ".npv"}, 64'(bif.next_pc_valid), 64'(v.tk));
        chk({nm, ".pc"}, 64'(bif.next_pc), 64'(v.pc));
        chk({nm, ".link"}, 64'(bif.next_link_reg), 64'(v.link));
        chk({nm, ".lv"}, 64'(bif.link_valid), 64'(v.lv));
        chk({nm, ".ovf"}, 64'(bif.ras_overflow), 64'(v.ovf));
        chk({nm, ".unf"}, 64'(bif.ras_underflow), 64'(v.unf));
        chk({nm, ".user"}, 64'(bif.user_data_out), 64'(v.tk));
    endtask

    task automatic issue(string nm, vec_t v);
        tick();
        drive(v);
        tick();
        bif.data_valid = 1'b0;
        tick();
        check_out(nm, v);
        tick();
        chk({nm, ".bv_gone"}, 64'(bif.branch_valid), 64'(0));
        chk({nm, ".fl_gone"}, 64'(bif.flush_pipeline), 64'(0));
    endtask

    initial begin
        vec_t v;
        int   nbv;
        int   saw_a;
        int   saw_b;

        bif.mem_ready = 1'b1;
        bif.data_valid = 1'b0;
        bif.is_branch = 1'b0;
        bif.is_cond_branch = 1'b0;
        bif.cond_code = 4'd0;
        bif.alu_flag_zero = 1'b0;
        bif.alu_flag_negative = 1'b0;
        bif.alu_flag_carry = 1'b0;
        bif.alu_flag_overflow = 1'b0;
        bif.branch_base_addr = '0;
        bif.branch_mode = 2'd0;
        bif.rn = '0;
        bif.lit = '0;
        bif.user_data_in = '0;

        tbl.push_back(mk(0, 14, 4'b0000, 0, 32'h100, 0, 32'h20,
                         1, 32'h122, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 4'b0100, 0, 32'h100, 0, 32'h20,
                         0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 14, 4'b0000, 2, 32'h40, 0, 32'h10,
                         1, 32'h52, 32'h42, 1, 0, 0));
        tbl.push_back(mk(0, 14, 4'b0000, 3, 0, 32'hDEAD, 0,
                         1, 32'h42, 0, 0, 0, 0));
        tbl.push_back(mk(0, 14, 4'b0000, 3, 0, 32'h1234, 0,
                         1, 32'h1234, 0, 0, 0, 1));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(mk(0, 14, 4'b0000, 2, 32'(k * 32'h1000), 0, 0,
                             1, 32'(k * 32'h1000 + 2), 32'(k * 32'h1000 + 2),
                             1, (k == 5), 0));
        for (int k = 5; k >= 2; k--)
            tbl.push_back(mk(0, 14, 4'b0000, 3, 0, 32'hBEEF, 0,
                             1, 32'(k * 32'h1000 + 2), 0, 0, 0, 0));
        tbl.push_back(mk(0, 14, 4'b0000, 3, 0, 32'hBEEF, 0,
                         1, 32'hBEEF, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'b0000, 2, 32'h80, 0, 32'h4,
                         0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8, 4'b0010, 1, 0, 32'h12345678, 0,
                         1, 32'h12345678, 0, 0, 0, 0));
        tbl.push_back(mk(1, 13, 4'b0101, 0, 32'h100, 0, 32'h20,
                         0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 11, 4'b0100, 0, 32'h100, 0, 32'hFFFFFFF0,
                         1, 32'hF2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 15, 4'b0000, 0, 32'h100, 0, 32'h20,
                         0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4'b0000, 0, 32'hFFFFFFFE, 0, 0,
                         1, 32'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 14, 4'b0000, 3, 0, 32'h55, 0,
                         1, 32'h55, 0, 0, 0, 1));

        tick();
        tick();
        chk("rst.bv", 64'(bif.branch_valid), 64'(0));
        chk("rst.flush", 64'(bif.flush_pipeline), 64'(0));
        chk("rst.pc", 64'(bif.next_pc), 64'(0));
        chk("rst.link", 64'(bif.next_link_reg), 64'(0));
        chk("rst.ready", 64'(bif.branch_ready), 64'(1));
        reset_n = 1'b1;

        foreach (tbl[i]) issue($sformatf("v%0d", i), tbl[i]);

        // flush squash: taken A, then B right behind it
        tick();
        drive(mk(0, 14, 0, 0, 32'h200, 0, 0, 1, 32'h202, 0, 0, 0, 0));
        tick();
        drive(mk(0, 14, 0, 1, 0, 32'h300, 0, 1, 32'h300, 0, 0, 0, 0));
        tick();
        bif.data_valid = 1'b0;
        nbv = 0; saw_a = 0; saw_b = 0;
        for (int i = 0; i < 5; i++) begin
            if (bif.branch_valid) nbv++;
            if (bif.next_pc_valid && bif.next_pc == 32'h202) saw_a++;
            if (bif.next_pc_valid && bif.next_pc == 32'h300) saw_b++;
            tick();
        end
        chk("flush.nbv", 64'(nbv), 64'(1));
        chk("flush.first", 64'(saw_a), 64'(1));
        chk("flush.second", 64'(saw_b), 64'(0));

        // stall 3 cycles with branch in S1
        drive(mk(0, 14, 0, 0, 32'h400, 0, 32'h4, 1, 32'h406, 0, 0, 0, 0));
        tick();
        bif.data_valid = 1'b0;
        bif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d.bv", i), 64'(bif.branch_valid), 64'(0));
            chk($sformatf("stall%0d.rdy", i), 64'(bif.branch_ready), 64'(0));
        end
        bif.mem_ready = 1'b1;
        chk("stall.pre_bv", 64'(bif.branch_valid), 64'(0));
        tick();
        check_out("stall.out", mk(0, 14, 0, 0, 0, 0, 0,
                                  1, 32'h406, 0, 0, 0, 0));
        bif.mem_ready = 1'b0;
        tick();
        chk("stall.hold_pc", 64'(bif.next_pc), 64'(32'h406));
        chk("stall.hold_fl", 64'(bif.flush_pipeline), 64'(0));
        bif.mem_ready = 1'b1;
        tick();
        tick();

        // push an entry, then reset with a branch in flight
        issue("rcall", mk(0, 14, 0, 2, 32'h600, 0, 0,
                          1, 32'h602, 32'h602, 1, 0, 0));
        drive(mk(0, 14, 0, 2, 32'h900, 0, 0, 1, 0, 0, 0, 0, 0));
        tick();
        bif.data_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("rs2.bv", 64'(bif.branch_valid), 64'(0));
        chk("rs2.flush", 64'(bif.flush_pipeline), 64'(0));
        chk("rs2.pc", 64'(bif.next_pc), 64'(0));
        chk("rs2.lv", 64'(bif.link_valid), 64'(0));
        chk("rs2.user", 64'(bif.user_data_out), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        chk("rs2.after_bv", 64'(bif.branch_valid), 64'(0));
        issue("rret", mk(0, 14, 0, 3, 0, 32'h777, 0,
                         1, 32'h777, 0, 0, 0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
